prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's 8-to-3 OR-gate encoder.
- Accepts an N-bit request vector per transaction and returns the binary index and one-hot grant of the winning request.
- Two modes: fixed priority (highest index wins) and round-robin.
- Flags no-request and multiple-request conditions; the old encoder gave no indication of either.
- Sits between request sources and a downstream consumer, using a valid/ready handshake on both sides.

Parameters:
- N, 8, number of request lines; N >= 2.
- W, 3, index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled on accept
- in_valid  input  1  req is valid
- in_ready  output  1  block can accept this cycle
- req  input  N  request vector; bit k = request k
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- out_idx  output  W  index of the granted request
- out_grant  output  N  one-hot grant; all zero if no request
- out_zero  output  1  accepted req was all zero
- out_multi  output  1  accepted req had more than one bit set

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, also mid-transaction):
  - out_valid, out_idx, out_grant, out_zero, out_multi = 0.
  - Round-robin pointer ptr = N-1.
  - Any held result is discarded.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: result registers load on the accept edge, so out_valid is high the cycle after accept.
- Throughput: one result per cycle while out_ready = 1.
- Hold: while out_valid && !out_ready, all out_* are stable and no accept occurs.
- Simultaneous events:
  - out_ready = 1 with accept: new result loads; out_valid stays 1.
  - out_ready = 1 without accept: out_valid -> 0. Other outputs keep their last values.
- Fixed mode (mode = 0): winner is the highest set bit index, consistent with the 8-to-3 encoder for one-hot input. ptr is not modified.
- Round-robin mode (mode = 1):
  - Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (descending, wraps modulo N).
  - The first set bit in that order wins.
  - After a grant g: ptr <= g-1, or N-1 when g = 0 (wrap-around).
- Zero request:
  - out_zero = 1, out_idx = 0, out_grant = 0, out_multi = 0, out_valid = 1.
  - ptr is unchanged.
- out_multi = 1 iff popcount(req) >= 2. out_zero and out_multi are mutually exclusive.
- out_grant = 1 << out_idx whenever out_zero = 0.
- Mode changes between transactions do not reset ptr. A fixed-mode transaction leaves ptr for the next round-robin transaction untouched.
- req and mode are ignored on cycles with no accept.
- No X on any output after reset, regardless of input values.

Test Plan (N = 8):
1. Reset: hold rst_n = 0 mid-transaction with out_valid = 1 -> all out_* = 0 immediately; in_ready = 1; the first round-robin result for req = 0xFF is idx 7.
2. Fixed one-hot sweep: req = 0x01, 0x02, ... 0x80 back-to-back, out_ready = 1 -> out_idx = 0..7 one cycle after each accept; out_multi = 0; out_grant = req.
3. Fixed multi: req = 0x2C -> out_idx = 5, out_grant = 0x20, out_multi = 1, out_zero = 0.
4. Round-robin rotation: req = 0xFF accepted nine times consecutively -> out_idx = 7, 6, 5, 4, 3, 2, 1, 0, 7 (wrap).
5. Backpressure:
   - out_ready = 0 after result idx 3; present req = 0x10 with in_valid = 1 -> in_ready = 0 and outputs hold idx 3 for 4 cycles.
   - Raise out_ready -> the same cycle accepts; the next cycle shows idx 4.
6. Zero and ptr retention (round-robin):
   - req = 0x10 -> idx 4.
   - req = 0x00 -> out_zero = 1, idx 0.
   - req = 0xFF -> idx 3 (ptr unaffected by the zero request).
   - Switch to mode 0 with req = 0x03 -> idx 1.
   - Back to mode 1 with req = 0xFF -> idx 2.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered N-way priority encoder, fixed or round-robin, valid/ready on both sides
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant,
  output logic         out_zero,
  output logic         out_multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic         accept;
  logic         req_zero;
  logic         req_multi;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign req_zero  = (req == '0);
  assign req_multi = |(req & (req - N'(1)));

  always_comb begin
    fix_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) fix_idx = W'(k);
    end
  end

  // Walk downward from ptr with wrap; the first set bit met wins.
  always_comb begin : rr_search
    logic [W-1:0] pos;
    logic         found;
    rr_idx = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr >= W'(i)) pos = ptr - W'(i);
      else              pos = ptr + W'(N - i);
      if (!found && req[pos]) begin
        rr_idx = pos;
        found  = 1'b1;
      end
    end
  end

  assign win_idx = mode ? rr_idx : fix_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_zero  <= req_zero;
      out_multi <= req_multi;
      out_idx   <= req_zero ? '0 : win_idx;
      out_grant <= req_zero ? '0 : (N'(1) << win_idx);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Only a real round-robin grant moves the pointer; zero requests and fixed mode leave it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (accept && mode && !req_zero) begin
      ptr <= (win_idx == '0) ? W'(N - 1) : win_idx - W'(1);
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - table-driven scoreboard bench for prio_encoder_rr (N = 8)
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_grant;
  logic       out_zero;
  logic       out_multi;

  typedef struct {
    logic       mode;
    logic [7:0] req;
    logic [2:0] idx;
    logic [7:0] grant;
    logic       zero;
    logic       multi;
  } vec_t;

  vec_t tbl [0:22];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  prio_encoder_rr #(.N(8), .W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_grant (out_grant),
    .out_zero  (out_zero),
    .out_multi (out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a result is compared on the cycle it is handed to the consumer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("out_idx",   32'(out_idx),   32'(e.idx));
        chk("out_grant", 32'(out_grant), 32'(e.grant));
        chk("out_zero",  32'(out_zero),  32'(e.zero));
        chk("out_multi", 32'(out_multi), 32'(e.multi));
      end
    end
  end

  task automatic send(input vec_t v);
    bit done;
    done     = 1'b0;
    mode     = v.mode;
    req      = v.req;
    in_valid = 1'b1;
    sb.push_back(v);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(tbl[i]);
    drain();
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b0, 8'(1 << k), 3'(k), 8'(1 << k), 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h2C, 3'd5, 8'h20, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++)
      tbl[9 + i] = '{1'b1, 8'hFF, 3'(7 - i), 8'(1 << ((7 - i) & 7)), 1'b0, 1'b1};
    tbl[18] = '{1'b1, 8'h10, 3'd4, 8'h10, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 8'hFF, 3'd3, 8'h08, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 8'h03, 3'd1, 8'h02, 1'b0, 1'b1};
    tbl[22] = '{1'b1, 8'hFF, 3'd2, 8'h04, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; req = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_no_x",  32'($isunknown({out_valid, out_idx, out_grant, out_zero, out_multi, in_ready})), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while a result is held: it is discarded and ptr returns to N-1.
    out_ready = 1'b0;
    send('{1'b1, 8'h04, 3'd2, 8'h04, 1'b0, 1'b0});
    @(negedge clk);
    chk("held_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_idx",   32'(out_idx),   32'd0);
    chk("async_grant", 32'(out_grant), 32'd0);
    chk("async_flags", 32'({out_zero, out_multi}), 32'd0);
    chk("async_ready", 32'(in_ready),  32'd1);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send('{1'b1, 8'hFF, 3'd7, 8'h80, 1'b0, 1'b1});
    drain();

    run_range(0, 8);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_range(9, 17);

    // Backpressure: idx 3 held while a new request waits.
    out_ready = 1'b0;
    send('{1'b0, 8'h08, 3'd3, 8'h08, 1'b0, 1'b0});
    mode = 1'b0; req = 8'h10; in_valid = 1'b1;
    sb.push_back('{1'b0, 8'h10, 3'd4, 8'h10, 1'b0, 1'b0});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready),  32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx",   32'(out_idx),   32'd3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_idx", 32'(out_idx), 32'd4);
    drain();

    run_range(18, 22);

    // Consumed without a new accept: valid drops, data holds.
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_idx",   32'(out_idx),   32'd2);
    chk("idle_grant", 32'(out_grant), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
